// File: rtl/id_ex_pkg.sv
// Shared types and default widths for the ID/EX pipeline register.
package id_ex_pkg;
    localparam int DATA_W_D  = 32;
    localparam int RADDR_W_D = 5;
    localparam int WB_W_D    = 2;
    localparam int MEM_W_D   = 3;
    localparam int EX_W_D    = 4;

    typedef struct packed {
        logic [WB_W_D-1:0]  wb;
        logic [MEM_W_D-1:0] mem;
        logic [EX_W_D-1:0]  ex;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [DATA_W_D-1:0]  inst_addr;
        logic [DATA_W_D-1:0]  rsdata;
        logic [DATA_W_D-1:0]  rtdata;
        logic [DATA_W_D-1:0]  imm;
        logic [RADDR_W_D-1:0] rsaddr;
        logic [RADDR_W_D-1:0] rtaddr;
        logic [RADDR_W_D-1:0] rdaddr;
    } id_ex_payload_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

    // Occupancy doubles as the control state: SKID is only ever valid behind MAIN.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;
endpackage

// File: rtl/id_ex_if.sv
// Decode-side and execute-side handshake plus payload of the ID/EX register.
interface id_ex_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int WB_W    = 2,
    parameter int MEM_W   = 3,
    parameter int EX_W    = 4
);
    logic               in_valid_i, in_ready_o;
    logic [WB_W-1:0]    wb_i;
    logic [MEM_W-1:0]   mem_i;
    logic [EX_W-1:0]    ex_i;
    logic [DATA_W-1:0]  inst_addr_i, rsdata_i, rtdata_i, imm_i;
    logic [RADDR_W-1:0] rsaddr_i, rtaddr_i, rdaddr_i;

    logic               out_valid_o, out_ready_i;
    logic [WB_W-1:0]    wb_o;
    logic [MEM_W-1:0]   mem_o;
    logic [EX_W-1:0]    ex_o;
    logic [DATA_W-1:0]  inst_addr_o, rsdata_o, rtdata_o, imm_o;
    logic [RADDR_W-1:0] rsaddr_o, rtaddr_o, rdaddr_o;
    logic [1:0]         occ_o;

    modport slave (
        input  in_valid_i, wb_i, mem_i, ex_i, inst_addr_i, rsdata_i, rtdata_i, imm_i,
               rsaddr_i, rtaddr_i, rdaddr_i, out_ready_i,
        output in_ready_o, out_valid_o, wb_o, mem_o, ex_o, inst_addr_o, rsdata_o,
               rtdata_o, imm_o, rsaddr_o, rtaddr_o, rdaddr_o, occ_o
    );

    modport master (
        output in_valid_i, wb_i, mem_i, ex_i, inst_addr_i, rsdata_i, rtdata_i, imm_i,
               rsaddr_i, rtaddr_i, rdaddr_i, out_ready_i,
        input  in_ready_o, out_valid_o, wb_o, mem_o, ex_o, inst_addr_o, rsdata_o,
               rtdata_o, imm_o, rsaddr_o, rtaddr_o, rdaddr_o, occ_o
    );
endinterface

// File: rtl/id_ex_slot.sv
// One pipeline slot: valid bit, control group and payload with load and clear.
module id_ex_slot #(
    parameter int CTRL_W = 9,
    parameter int PAY_W  = 143
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [PAY_W-1:0]  pay_i,
    output logic              vld_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [PAY_W-1:0]  pay_o
);
    logic              vld_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [PAY_W-1:0]  pay_q;

    // Clear wins over load and zeroes control only; payload may stay stale.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
            pay_q  <= '0;
        end else if (clr_i) begin
            vld_q  <= 1'b0;
            ctrl_q <= '0;
        end else if (load_i) begin
            vld_q  <= 1'b1;
            ctrl_q <= ctrl_i;
            pay_q  <= pay_i;
        end
    end

    assign vld_o  = vld_q;
    assign ctrl_o = ctrl_q;
    assign pay_o  = pay_q;
endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a one-entry skid buffer and synchronous flush.
module id_ex_pipe
    import id_ex_pkg::*;
#(
    parameter int DATA_W  = DATA_W_D,
    parameter int RADDR_W = RADDR_W_D,
    parameter int WB_W    = WB_W_D,
    parameter int MEM_W   = MEM_W_D,
    parameter int EX_W    = EX_W_D
) (
    input  logic    clk_i,
    input  logic    rst_n_i,
    input  logic    flush_i,
    id_ex_if.slave  bus
);
    localparam int CTRL_W = WB_W + MEM_W + EX_W;
    localparam int PAY_W  = 4 * DATA_W + 3 * RADDR_W;

    logic [CTRL_W-1:0] in_ctrl, main_ctrl, skid_ctrl, main_ctrl_d;
    logic [PAY_W-1:0]  in_pay, main_pay, skid_pay, main_pay_d;
    logic              main_vld, skid_vld, main_ld, main_clr, skid_ld, skid_clr;
    logic              accept, pop;
    occ_e              occ;

    assign in_ctrl = {bus.wb_i, bus.mem_i, bus.ex_i};
    assign in_pay  = {bus.inst_addr_i, bus.rsdata_i, bus.rtdata_i, bus.imm_i,
                      bus.rsaddr_i, bus.rtaddr_i, bus.rdaddr_i};

    // Ready depends only on registered state, never on out_ready_i.
    assign bus.in_ready_o = !skid_vld;
    assign accept = bus.in_valid_i && !skid_vld;
    assign pop    = main_vld && bus.out_ready_i;

    always_comb begin
        occ = OCC_EMPTY;
        if (skid_vld)      occ = OCC_FULL;
        else if (main_vld) occ = OCC_ONE;
    end

    always_comb begin
        main_ld     = 1'b0;
        main_clr    = 1'b0;
        skid_ld     = 1'b0;
        skid_clr    = 1'b0;
        main_ctrl_d = in_ctrl;
        main_pay_d  = in_pay;
        if (flush_i) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (occ)
                OCC_EMPTY: main_ld = accept;
                OCC_ONE: begin
                    if (pop) begin
                        main_ld  = accept;
                        main_clr = !accept;
                    end else begin
                        skid_ld  = accept;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        main_ld     = 1'b1;
                        skid_clr    = 1'b1;
                        main_ctrl_d = skid_ctrl;
                        main_pay_d  = skid_pay;
                    end
                end
                default: ;
            endcase
        end
    end

    id_ex_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_main (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(main_ld), .clr_i(main_clr),
        .ctrl_i(main_ctrl_d), .pay_i(main_pay_d),
        .vld_o(main_vld), .ctrl_o(main_ctrl), .pay_o(main_pay)
    );

    id_ex_slot #(.CTRL_W(CTRL_W), .PAY_W(PAY_W)) u_skid (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .load_i(skid_ld), .clr_i(skid_clr),
        .ctrl_i(in_ctrl), .pay_i(in_pay),
        .vld_o(skid_vld), .ctrl_o(skid_ctrl), .pay_o(skid_pay)
    );

    // Gate control with valid so an empty head is always a bubble.
    assign {bus.wb_o, bus.mem_o, bus.ex_o} = main_vld ? main_ctrl : '0;
    assign {bus.inst_addr_o, bus.rsdata_o, bus.rtdata_o, bus.imm_o,
            bus.rsaddr_o, bus.rtaddr_o, bus.rdaddr_o} = main_pay;
    assign bus.out_valid_o = main_vld;
    assign bus.occ_o       = {1'b0, main_vld} + {1'b0, skid_vld};
endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed and model-checked stimulus for the ID/EX pipeline register.
module tb_id_ex_pipe;
    import id_ex_pkg::*;

    typedef struct packed {
        id_ex_ctrl_t    c;
        id_ex_payload_t p;
    } pkt_t;

    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    int   checks = 0, errors = 0;
    pkt_t q[$];

    always #5 clk = ~clk;

    id_ex_if bus ();
    id_ex_pipe dut (.clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .bus(bus));

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic pkt_t mk(input int k);
        pkt_t x;
        x.c.wb        = 2'(k);
        x.c.mem       = 3'(k + 2);
        x.c.ex        = 4'(k + 1);
        x.p.inst_addr = 32'h0000_1000 + 32'(k * 4);
        x.p.rsdata    = 32'hA000_0000 + 32'(k);
        x.p.rtdata    = 32'hB000_0000 + 32'(k);
        x.p.imm       = 32'(k);
        x.p.rsaddr    = 5'(k);
        x.p.rtaddr    = 5'(k + 1);
        x.p.rdaddr    = 5'(k + 2);
        return x;
    endfunction

    function automatic pkt_t rnd();
        pkt_t x;
        x.c           = id_ex_ctrl_t'($urandom_range(0, 511));
        x.p.inst_addr = $urandom();
        x.p.rsdata    = $urandom();
        x.p.rtdata    = $urandom();
        x.p.imm       = $urandom();
        x.p.rsaddr    = 5'($urandom_range(0, 31));
        x.p.rtaddr    = 5'($urandom_range(0, 31));
        x.p.rdaddr    = 5'($urandom_range(0, 31));
        return x;
    endfunction

    function automatic pkt_t obs();
        pkt_t o;
        o.c = {bus.wb_o, bus.mem_o, bus.ex_o};
        o.p = {bus.inst_addr_o, bus.rsdata_o, bus.rtdata_o, bus.imm_o,
               bus.rsaddr_o, bus.rtaddr_o, bus.rdaddr_o};
        return o;
    endfunction

    task automatic drive(input pkt_t x, input logic v);
        bus.in_valid_i = v;
        {bus.wb_i, bus.mem_i, bus.ex_i} = x.c;
        {bus.inst_addr_i, bus.rsdata_i, bus.rtdata_i, bus.imm_i,
         bus.rsaddr_i, bus.rtaddr_i, bus.rdaddr_i} = x.p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        pkt_t x;
        bit   v, r, f, pop, acc;
        x = '0;
        drive(x, 1'b0);
        bus.out_ready_i = 1'b0;

        // Reset state
        #3;
        chk("rst_valid", 160'(bus.out_valid_o), 160'(0));
        chk("rst_ready", 160'(bus.in_ready_o), 160'(1));
        chk("rst_occ", 160'(bus.occ_o), 160'(0));
        chk("rst_ctrl", 160'(obs().c), 160'(CTRL_BUBBLE));
        chk("rst_pay", 160'(obs().p), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // First instruction, one-cycle latency
        x = '0;
        x.c.ex = 4'hA;
        x.p.rsdata = 32'h1234;
        drive(x, 1'b1);
        bus.out_ready_i = 1'b1;
        tick();
        chk("first_valid", 160'(bus.out_valid_o), 160'(1));
        chk("first_ex", 160'(bus.ex_o), 160'(4'hA));
        chk("first_rs", 160'(bus.rsdata_o), 160'(32'h1234));

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            drive(mk(i), 1'b1);
            tick();
            chk("stream_pkt", 160'(obs()), 160'(mk(i)));
            chk("stream_occ", 160'(bus.occ_o), 160'(1));
        end
        drive(mk(0), 1'b0);
        tick();
        chk("drain_valid", 160'(bus.out_valid_o), 160'(0));
        chk("drain_occ", 160'(bus.occ_o), 160'(0));
        chk("drain_bubble", 160'(obs().c), 160'(CTRL_BUBBLE));

        // Fill the skid, refuse a third, then drain in order
        bus.out_ready_i = 1'b0;
        drive(mk(20), 1'b1);
        tick();
        drive(mk(21), 1'b1);
        tick();
        chk("full_occ", 160'(bus.occ_o), 160'(2));
        chk("full_ready", 160'(bus.in_ready_o), 160'(0));
        chk("full_head", 160'(obs()), 160'(mk(20)));
        drive(mk(22), 1'b1);
        tick();
        chk("refuse_occ", 160'(bus.occ_o), 160'(2));
        chk("refuse_head", 160'(obs()), 160'(mk(20)));
        bus.out_ready_i = 1'b1;
        drive(mk(22), 1'b0);
        tick();
        chk("drain_b", 160'(obs()), 160'(mk(21)));
        chk("drain_b_occ", 160'(bus.occ_o), 160'(1));
        chk("drain_b_rdy", 160'(bus.in_ready_o), 160'(1));
        drive(mk(22), 1'b1);
        tick();
        chk("drain_c", 160'(obs()), 160'(mk(22)));
        drive(mk(22), 1'b0);
        tick();
        chk("drain_end_occ", 160'(bus.occ_o), 160'(0));

        // Flush while full with a same-cycle input
        bus.out_ready_i = 1'b0;
        drive(mk(30), 1'b1);
        tick();
        drive(mk(31), 1'b1);
        tick();
        chk("pre_flush_occ", 160'(bus.occ_o), 160'(2));
        flush = 1'b1;
        drive(mk(32), 1'b1);
        tick();
        flush = 1'b0;
        drive(mk(32), 1'b0);
        chk("flush_occ", 160'(bus.occ_o), 160'(0));
        chk("flush_valid", 160'(bus.out_valid_o), 160'(0));
        chk("flush_ctrl", 160'(obs().c), 160'(CTRL_BUBBLE));
        chk("flush_ready", 160'(bus.in_ready_o), 160'(1));
        tick();
        chk("flush_lost", 160'(bus.occ_o), 160'(0));

        // Flush coinciding with a pop still ends empty
        bus.out_ready_i = 1'b1;
        drive(mk(33), 1'b1);
        tick();
        chk("fp_pre_occ", 160'(bus.occ_o), 160'(1));
        drive(mk(34), 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(mk(34), 1'b0);
        chk("fp_occ", 160'(bus.occ_o), 160'(0));

        // Asynchronous reset while full
        bus.out_ready_i = 1'b0;
        drive(mk(40), 1'b1);
        tick();
        drive(mk(41), 1'b1);
        tick();
        drive(mk(41), 1'b0);
        chk("ar_pre_occ", 160'(bus.occ_o), 160'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_occ", 160'(bus.occ_o), 160'(0));
        chk("ar_valid", 160'(bus.out_valid_o), 160'(0));
        chk("ar_ready", 160'(bus.in_ready_o), 160'(1));
        chk("ar_ctrl", 160'(obs().c), 160'(CTRL_BUBBLE));
        chk("ar_pay", 160'(obs().p), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_post_occ", 160'(bus.occ_o), 160'(0));

        // Random traffic against a queue model
        q.delete();
        for (int n = 0; n < 10000; n++) begin
            chk("rnd_valid", 160'(bus.out_valid_o), 160'(q.size() > 0));
            chk("rnd_occ", 160'(bus.occ_o), 160'(q.size()));
            chk("rnd_ready", 160'(bus.in_ready_o), 160'(q.size() < 2));
            if (q.size() > 0) chk("rnd_pkt", 160'(obs()), 160'(q[0]));
            else              chk("rnd_bubble", 160'(obs().c), 160'(CTRL_BUBBLE));
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 31) == 0);
            x = rnd();
            drive(x, v);
            bus.out_ready_i = r;
            flush = f;
            if (f) begin
                q.delete();
            end else begin
                pop = (q.size() > 0) && r;
                acc = v && (q.size() < 2);
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(x);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
# id_ex_pipe

Parametrised ID/EX pipeline register with a valid/ready handshake, a one-entry skid buffer and a synchronous flush. It sits between the decode stage and the execute stage of the core and carries WB/MEM/EX control groups, the instruction address, both register operands, the sign-extended immediate and the rs/rt/rd register addresses. Unlike a plain pipeline latch, it can absorb one extra instruction when execute stalls, and it can squash its contents on a branch/hazard flush. Squashed or empty slots always present all-zero control fields, which is a guaranteed bubble.

## Interface
Parameters:
- DATA_W, 32, width of inst_addr, rsdata, rtdata and imm
- RADDR_W, 5, register-address width
- WB_W, 2, WB control-group width
- MEM_W, 3, MEM control-group width
- EX_W, 4, EX control-group width

Ports (name, direction, width, meaning):
- clk_i  in  1  single clock; everything is on its rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous squash of all held entries
- in_valid_i  in  1  decode presents an instruction
- in_ready_o  out  1  block can accept an instruction this cycle
- wb_i / mem_i / ex_i  in  WB_W / MEM_W / EX_W  control groups
- inst_addr_i, rsdata_i, rtdata_i, imm_i  in  DATA_W each  payload
- rsaddr_i, rtaddr_i, rdaddr_i  in  RADDR_W each  register addresses
- out_valid_o  out  1  execute-side entry valid
- out_ready_i  in  1  execute consumes the entry this cycle
- wb_o, mem_o, ex_o, inst_addr_o, rsdata_o, rtdata_o, imm_o, rsaddr_o, rtaddr_o, rdaddr_o  out  same widths as inputs  registered payload of the head entry
- occ_o  out  2  number of valid entries held (0..2)

## Operation
- The block has two slots. MAIN drives the outputs. SKID holds an overflow entry.
- State is encoded by occupancy: EMPTY (0), ONE (MAIN valid), FULL (MAIN and SKID valid). SKID is never valid while MAIN is empty.
- Accept is defined as in_valid_i && in_ready_o. Pop is defined as out_valid_o && out_ready_i.
- in_ready_o = !skid_valid. It is a pure function of registered state, with no combinational path from out_ready_i.
- Transitions when flush_i = 0:
  - EMPTY + accept → ONE (MAIN ← input).
  - ONE + accept + pop → ONE (MAIN ← input).
  - ONE + accept + no pop → FULL (SKID ← input).
  - ONE + pop + no accept → EMPTY.
  - FULL + pop → ONE (MAIN ← SKID). In this state no accept is possible.
  - Otherwise the state holds.
- flush_i = 1 overrides everything that cycle:
  - Both valid bits clear. The same-cycle input is discarded, even if in_valid_i && in_ready_o.
  - WB, MEM and EX fields of both slots are zeroed.
  - Data and address fields may keep stale values.
- Bubble rule: whenever out_valid_o = 0, wb_o, mem_o and ex_o are 0.
- Payload is passed bit-exact. No arithmetic is performed, and widths in equal widths out.
- occ_o = MAIN.valid + SKID.valid.

## Timing
- Reset (rst_n_i low, asynchronous) forces the following, held until the first clock edge after release:
  - out_valid_o = 0, occ_o = 0, in_ready_o = 1.
  - All output payload and control fields = 0.
- Latency: an input accepted at edge N appears on the outputs after edge N (one cycle) when MAIN is free or popping.
- Throughput is one instruction per cycle with out_ready_i held high.
- Output data stays stable while out_valid_o = 1 and out_ready_i = 0.
- Reset asserted mid-operation drops all entries immediately. No partial state survives.
- If flush_i and reset are both active, reset wins.
- A flush and a pop in the same cycle: the pop counts as consumed by execute, and the block still ends EMPTY.

## Structure
- Package id_ex_pkg holds:
  - the default width localparams;
  - the packed struct id_ex_ctrl_t {wb, mem, ex};
  - the packed struct id_ex_payload_t (addr/data/reg-addr fields);
  - the constant CTRL_BUBBLE = '0.
- Sub-module id_ex_slot is one valid + ctrl + payload register with load, clear-ctrl and async reset. It is instantiated twice (MAIN, SKID).
- The top level contains only the occupancy next-state logic and the output muxing.

## Test plan
- Reset → out_valid_o=0, in_ready_o=1, occ_o=0, wb_o/mem_o/ex_o=0. Release, push ex_i=4'hA, rsdata_i=32'h1234 with out_ready_i=1 → next cycle out_valid_o=1, ex_o=4'hA, rsdata_o=32'h1234.
- Stream 8 instructions with out_ready_i=1 → one output per cycle, same order, occ_o=1 throughout.
- out_ready_i=0 and push A, B → occ_o=2, in_ready_o=0, outputs show A. Push C is refused. Then out_ready_i=1 → A, B, C emerge on consecutive cycles.
- FULL plus flush_i=1 with in_valid_i=1 → next cycle occ_o=0, out_valid_o=0, wb_o=mem_o=ex_o=0, and the input is lost.
- Assert rst_n_i low mid-clock while FULL → outputs clear asynchronously before the next edge.
- Random in_valid_i/out_ready_i/flush_i over 10k cycles against a reference queue model → sequence matches, no loss or duplication outside flushes.
